mult_arbiter: RTL and testbench

Shares a single sequential `multiplier` instance between `NUM_REQ` requesters. It uses the same STB/ACK handshake that `multiplier` uses on both its operand and result sides. The block accepts one operand pair at a time using round-robin arbitration, sequences it through the multiplier, and returns the product to the owning requester. It sits between the requesting datapath blocks and the multiplier, and `CLK`/`RST` are common to both.

---
 rtl/mult_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 30 +++
 rtl/mult_arbiter.sv | 121 ++++++++++++
 tb/tb_mult_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// mult_pkg: shared FSM states, handshake helpers and width derivation for the multiplier arbiter
package mult_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  localparam logic HS_ON = 1'b1;
  localparam logic HS_OFF = 1'b0;
  function automatic int p_width(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction
  function automatic logic xfer(input logic stb, input logic ack);
    return stb & ack;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request above the last grant
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    gnt_idx,
  output logic               any_req
);
  logic [ID_W-1:0] idx;
  logic found;
  // walk last+1 .. last+NUM_REQ (mod NUM_REQ) and keep the first hit
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((32'(last) + k) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        gnt[idx] = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  assign any_req = |req;
endmodule

// File: rtl/mult_arbiter.sv
// mult_arbiter: round-robin sharing of one sequential multiplier between NUM_REQ requesters
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int A_WIDTH = 16,
  parameter int B_WIDTH = 16,
  localparam int P_WIDTH = p_width(A_WIDTH, B_WIDTH),
  localparam int ID_W = ($clog2(NUM_REQ) > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         REQ_STB,
  output logic [NUM_REQ-1:0]         REQ_ACK,
  input  logic [NUM_REQ*A_WIDTH-1:0] REQ_DAT_A,
  input  logic [NUM_REQ*B_WIDTH-1:0] REQ_DAT_B,
  output logic [P_WIDTH-1:0]         RSP_DAT,
  output logic [NUM_REQ-1:0]         RSP_STB,
  input  logic [NUM_REQ-1:0]         RSP_ACK,
  output logic [A_WIDTH-1:0]         M_DAT_A,
  output logic [B_WIDTH-1:0]         M_DAT_B,
  output logic                       M_STB,
  input  logic                       M_ACK,
  input  logic [P_WIDTH-1:0]         M_RES,
  input  logic                       M_RES_STB,
  output logic                       M_RES_ACK,
  output logic                       BUSY
);
  state_t state_q, state_d;
  logic [ID_W-1:0] owner_q, owner_d, last_q, last_d, gnt_idx;
  logic [NUM_REQ-1:0] req_ack_q, req_ack_d, rsp_stb_q, rsp_stb_d, gnt;
  logic [A_WIDTH-1:0] m_dat_a_q, m_dat_a_d;
  logic [B_WIDTH-1:0] m_dat_b_q, m_dat_b_d;
  logic [P_WIDTH-1:0] rsp_dat_q, rsp_dat_d;
  logic m_stb_q, m_stb_d, m_res_ack_q, m_res_ack_d, any_req;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr (
    .req(REQ_STB),
    .last(last_q),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .any_req(any_req)
  );

  // one operation at a time: grant, issue to multiplier, capture result, hand back to owner
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d = last_q;
    req_ack_d = '0;
    rsp_stb_d = rsp_stb_q;
    m_dat_a_d = m_dat_a_q;
    m_dat_b_d = m_dat_b_q;
    m_stb_d = m_stb_q;
    m_res_ack_d = HS_OFF;
    rsp_dat_d = rsp_dat_q;
    case (state_q)
      IDLE: if (any_req) begin
        state_d = ISSUE;
        owner_d = gnt_idx;
        last_d = gnt_idx;
        req_ack_d = gnt;
        m_stb_d = HS_ON;
        m_dat_a_d = REQ_DAT_A[gnt_idx*A_WIDTH +: A_WIDTH];
        m_dat_b_d = REQ_DAT_B[gnt_idx*B_WIDTH +: B_WIDTH];
      end
      ISSUE: if (xfer(m_stb_q, M_ACK)) begin
        state_d = WAIT;
        m_stb_d = HS_OFF;
      end
      WAIT: if (M_RES_STB) begin
        state_d = RESP;
        rsp_dat_d = M_RES;
        m_res_ack_d = HS_ON;
        rsp_stb_d = '0;
        rsp_stb_d[owner_q] = HS_ON;
      end
      RESP: if (xfer(rsp_stb_q[owner_q], RSP_ACK[owner_q])) begin
        state_d = IDLE;
        rsp_stb_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // state registers; reset leaves last at the top so requester 0 wins first
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q <= ID_W'(NUM_REQ - 1);
      req_ack_q <= '0;
      rsp_stb_q <= '0;
      m_dat_a_q <= '0;
      m_dat_b_q <= '0;
      m_stb_q <= HS_OFF;
      m_res_ack_q <= HS_OFF;
      rsp_dat_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q <= last_d;
      req_ack_q <= req_ack_d;
      rsp_stb_q <= rsp_stb_d;
      m_dat_a_q <= m_dat_a_d;
      m_dat_b_q <= m_dat_b_d;
      m_stb_q <= m_stb_d;
      m_res_ack_q <= m_res_ack_d;
      rsp_dat_q <= rsp_dat_d;
    end
  end

  assign REQ_ACK = req_ack_q;
  assign RSP_STB = rsp_stb_q;
  assign RSP_DAT = rsp_dat_q;
  assign M_DAT_A = m_dat_a_q;
  assign M_DAT_B = m_dat_b_q;
  assign M_STB = m_stb_q;
  assign M_RES_ACK = m_res_ack_q;
  assign BUSY = state_q != IDLE;
endmodule

// File: tb/tb_mult_arbiter.sv
// tb_mult_arbiter: scoreboard bench for mult_arbiter driving a behavioural sequential multiplier
module tb_mult_arbiter;
  localparam int N = 4;
  localparam int AW = 16;
  localparam int BW = 16;
  localparam int PW = 32;
  localparam int LAT = 3;
  typedef struct { int id; logic [AW-1:0] a; logic [BW-1:0] b; } gnt_t;
  typedef struct { int id; logic [PW-1:0] p; } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req_stb = '0;
  logic [N-1:0] rsp_ack = '0;
  logic [N*AW-1:0] req_a = '0;
  logic [N*BW-1:0] req_b = '0;
  logic [N-1:0] req_ack, rsp_stb;
  logic [PW-1:0] rsp_dat, m_res, prod;
  logic [AW-1:0] m_dat_a;
  logic [BW-1:0] m_dat_b;
  logic m_stb, m_ack, m_res_stb, m_res_ack, busy, m_busy;
  int m_cnt;

  gnt_t gnt_q[$];
  rsp_t exp_q[$];
  logic [AW-1:0] op_a[N][8];
  logic [BW-1:0] op_b[N][8];
  int op_n[N];
  int op_i[N];
  int n_chk = 0;
  int n_err = 0;
  int rsp_hold = 0;
  int hcnt = 0;

  always #5 clk = ~clk;

  mult_arbiter #(.NUM_REQ(N), .A_WIDTH(AW), .B_WIDTH(BW)) dut (
    .CLK(clk), .RST(rst),
    .REQ_STB(req_stb), .REQ_ACK(req_ack), .REQ_DAT_A(req_a), .REQ_DAT_B(req_b),
    .RSP_DAT(rsp_dat), .RSP_STB(rsp_stb), .RSP_ACK(rsp_ack),
    .M_DAT_A(m_dat_a), .M_DAT_B(m_dat_b), .M_STB(m_stb), .M_ACK(m_ack),
    .M_RES(m_res), .M_RES_STB(m_res_stb), .M_RES_ACK(m_res_ack), .BUSY(busy)
  );

  // multiplier model: ready when idle, LAT cycles of work, result held until O_ACK
  assign m_ack = !m_busy && !m_res_stb;
  assign m_res = m_res_stb ? prod : 32'hDEAD_BEEF;
  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_res_stb <= 1'b0;
      m_cnt <= 0;
      prod <= '0;
    end else if (m_stb && m_ack) begin
      m_busy <= 1'b1;
      m_cnt <= LAT;
      prod <= PW'(m_dat_a) * PW'(m_dat_b);
    end else if (m_busy) begin
      if (m_cnt == 1) begin
        m_busy <= 1'b0;
        m_res_stb <= 1'b1;
      end
      m_cnt <= m_cnt - 1;
    end else if (m_res_stb && m_res_ack) begin
      m_res_stb <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic add_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b);
    op_a[i][op_n[i]] = a;
    op_b[i][op_n[i]] = b;
    op_n[i]++;
  endtask

  task automatic expect_op(input int i, input logic [AW-1:0] a, input logic [BW-1:0] b, input logic [PW-1:0] p);
    gnt_q.push_back(gnt_t'{i, a, b});
    exp_q.push_back(rsp_t'{i, p});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < N; i++) begin
      op_n[i] = 0;
      op_i[i] = 0;
    end
    gnt_q.delete();
    exp_q.delete();
    @(negedge clk);
    chk("rst_req_ack", req_ack, 0);
    chk("rst_rsp_stb", rsp_stb, 0);
    chk("rst_m_stb", m_stb, 0);
    chk("rst_m_res_ack", m_res_ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_m_dat_a", m_dat_a, 0);
    chk("rst_m_dat_b", m_dat_b, 0);
    rst = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while ((gnt_q.size() != 0 || exp_q.size() != 0 || busy) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_drained"}, 64'(gnt_q.size() + exp_q.size()), 0);
    chk({tag, "_idle"}, busy, 0);
  endtask

  // requesters: hold STB with the current operands until ACK, then move to the next op
  initial forever begin
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (req_ack[i] && op_i[i] < op_n[i]) op_i[i]++;
      req_stb[i] = !rst && op_i[i] < op_n[i];
      req_a[i*AW +: AW] = op_a[i][op_i[i] % 8];
      req_b[i*BW +: BW] = op_b[i][op_i[i] % 8];
    end
  end

  // result consumer: optionally stall, acking only non-owners while stalled
  initial forever begin
    @(negedge clk);
    if (rst || rsp_stb == 0) begin
      rsp_ack = '0;
      hcnt = 0;
    end else if (hcnt < rsp_hold) begin
      hcnt++;
      rsp_ack = ~rsp_stb;
    end else begin
      rsp_ack = rsp_stb;
    end
  end

  // monitor: pops grants and responses off the scoreboard as the DUT produces them
  initial begin
    gnt_t g;
    rsp_t e;
    logic [N-1:0] p_ack = '0;
    logic [N-1:0] p_stb = '0;
    logic p_mstb = 1'b0;
    logic p_mra = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        p_ack = '0;
        p_stb = '0;
        p_mstb = 1'b0;
        p_mra = 1'b0;
      end else begin
        if (req_ack != 0) begin
          if (gnt_q.size() == 0) chk("grant_unexpected", req_ack, 0);
          else begin
            g = gnt_q.pop_front();
            chk("grant", req_ack, 64'(1) << g.id);
            chk("m_stb_rise", {p_mstb, m_stb}, 2'b01);
            chk("m_dat", {m_dat_a, m_dat_b}, {g.a, g.b});
          end
        end
        if (p_ack != 0) chk("req_ack_pulse", req_ack, 0);
        if (rsp_stb != 0 && p_stb == 0) begin
          if (exp_q.size() == 0) chk("rsp_unexpected", rsp_stb, 0);
          else begin
            e = exp_q.pop_front();
            chk("rsp_stb", rsp_stb, 64'(1) << e.id);
            chk("rsp_dat", rsp_dat, e.p);
            chk("m_res_ack", m_res_ack, 1);
          end
        end
        if (p_mra) chk("m_res_ack_pulse", m_res_ack, 0);
        p_ack = req_ack;
        p_stb = rsp_stb;
        p_mstb = m_stb;
        p_mra = m_res_ack;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    do_reset();
    add_op(0, 511, 63);
    expect_op(0, 511, 63, 32193);
    wait_done("single");

    do_reset();
    add_op(0, 2, 3); add_op(1, 4, 5); add_op(2, 6, 7); add_op(3, 8, 9);
    expect_op(0, 2, 3, 6); expect_op(1, 4, 5, 20); expect_op(2, 6, 7, 42); expect_op(3, 8, 9, 72);
    wait_done("four");

    do_reset();
    add_op(1, 5, 5);
    expect_op(1, 5, 5, 25);
    wait_done("fair_setup");
    add_op(1, 10, 11); add_op(1, 12, 13); add_op(3, 20, 21); add_op(3, 22, 23);
    expect_op(3, 20, 21, 420); expect_op(1, 10, 11, 110); expect_op(3, 22, 23, 506); expect_op(1, 12, 13, 156);
    wait_done("fair");

    do_reset();
    rsp_hold = 20;
    add_op(0, 3, 5); add_op(2, 100, 200);
    expect_op(0, 3, 5, 15); expect_op(2, 100, 200, 20000);
    k = 0;
    while (rsp_stb == 0 && k < 200) begin @(negedge clk); k++; end
    chk("bp_first_rsp", rsp_stb, 4'b0001);
    for (int c = 0; c < 20; c++) begin
      chk("bp_rsp_stb", rsp_stb, 4'b0001);
      chk("bp_rsp_dat", rsp_dat, 15);
      chk("bp_m_stb", m_stb, 0);
      chk("bp_req_ack", req_ack, 0);
      @(negedge clk);
    end
    k = 0;
    while (rsp_stb != 0 && k < 50) begin @(negedge clk); k++; end
    chk("bp_released", rsp_stb, 0);
    chk("bp_no_early_grant", req_ack, 0);
    @(negedge clk);
    chk("bp_regrant", req_ack, 4'b0100);
    wait_done("backpressure");
    rsp_hold = 0;

    add_op(0, 1000, 1000);
    expect_op(0, 1000, 1000, 1000000);
    k = 0;
    while (!(busy && !m_stb) && k < 100) begin @(negedge clk); k++; end
    chk("wait_reached", {busy, m_stb, m_res_ack, rsp_stb}, {3'b100, 4'b0000});
    do_reset();
    add_op(2, 7, 9);
    expect_op(2, 7, 9, 63);
    wait_done("after_reset");

    add_op(1, 16'hFFFF, 16'hFFFF);
    expect_op(1, 16'hFFFF, 16'hFFFF, 32'd4294836225);
    wait_done("max");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
